// File: rtl/msx_joyport_pkg.sv
// Shared types and constants for the MSX joystick-port controller.
package msx_joyport_pkg;

    // Which device currently owns the joystick port.
    typedef enum logic {
        MODE_JOY   = 1'b0,
        MODE_MOUSE = 1'b1
    } mode_t;

    // Position within the four-nibble mouse read sequence.
    typedef enum logic [1:0] {
        NIB_N0 = 2'd0,
        NIB_N1 = 2'd1,
        NIB_N2 = 2'd2,
        NIB_N3 = 2'd3
    } nib_t;

    // Idle clk_sys cycles without a strobe edge before the sequence restarts.
    localparam int DEFAULT_TIMEOUT = 100000;

    // Width of the mouse motion accumulators and snapshots.
    localparam int ACC_W = 8;

endpackage

// File: rtl/sat_acc8.sv
// Saturating 8-bit accumulate step: base + (optionally negated) 9-bit delta,
// computed at 10 bits and clamped to -128..+127.
module sat_acc8
    import msx_joyport_pkg::*;
(
    input  logic signed [ACC_W-1:0] base,
    input  logic signed [8:0]       delta,
    input  logic                    negate,
    output logic signed [ACC_W-1:0] sum
);

    // 10 bits hold -256..+256 for the delta and -384..+383 for the sum.
    localparam logic signed [9:0] SAT_MAX = 10'sd127;
    localparam logic signed [9:0] SAT_MIN = -10'sd128;

    logic signed [9:0] delta_ext;
    logic signed [9:0] sum_wide;

    // Widen, optionally negate, add and clamp.
    // NOTE: every combinational output gets a value on every path (defaults first), otherwise a latch is inferred.
    always_comb begin
        delta_ext = {delta[8], delta};
        if (negate) begin
            delta_ext = -delta_ext;
        end
        sum_wide = {{(10 - ACC_W){base[ACC_W-1]}}, base} + delta_ext;
        sum      = sum_wide[ACC_W-1:0];
        if (sum_wide > SAT_MAX) begin
            sum = 8'sh7F;
        end else if (sum_wide < SAT_MIN) begin
            sum = 8'sh80;
        end
    end

endmodule

// File: rtl/msx_joyport_ctrl.sv
// MSX general-purpose port controller: presents either a digital joystick or
// an MSX mouse (four strobe-clocked nibbles) on the PSG port A pins.
module msx_joyport_ctrl
    import msx_joyport_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [5:0]  joy_a_n,
    input  logic [8:0]  mouse_x,
    input  logic [8:0]  mouse_y,
    input  logic [1:0]  mouse_btn,
    input  logic        mouse_strobe,
    input  logic        stra,
    output logic [5:0]  port_a,
    output logic        mouse_active
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TMO_LOAD = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  TMO_ONE  = CNT_W'(1);
    // The restart fires on the clock where the counter steps from 2 to 1.
    localparam logic [CNT_W:0]    TMO_FIRE = (CNT_W + 1)'(2);

    mode_t                   mode, mode_next;
    nib_t                    nib, nib_next;
    logic                    stra_q;
    logic signed [ACC_W-1:0] acc_x, acc_y;
    logic signed [ACC_W-1:0] snap_x, snap_y;
    logic [1:0]              btn_q;
    logic [CNT_W-1:0]        tmo_cnt;

    logic                    stra_edge;
    logic                    mouse_exit;
    logic                    take_edge;
    logic                    snap_take;
    logic                    tmo_fire;
    logic signed [ACC_W-1:0] acc_x_base, acc_y_base;
    logic signed [ACC_W-1:0] acc_x_sum, acc_y_sum;
    logic signed [ACC_W-1:0] snap_x_view;
    logic [3:0]              nib_out;

    // Saturating update of the X accumulator; MSX counts left as positive.
    sat_acc8 u_sat_x (
        .base   (acc_x_base),
        .delta  (mouse_x),
        .negate (1'b1),
        .sum    (acc_x_sum)
    );

    // Saturating update of the Y accumulator; up is positive on both sides.
    sat_acc8 u_sat_y (
        .base   (acc_y_base),
        .delta  (mouse_y),
        .negate (1'b0),
        .sum    (acc_y_sum)
    );

    // Edge detection, mode-exit, snapshot and timeout qualifiers plus the nibble mux.
    always_comb begin
        stra_edge  = (stra != stra_q);
        mouse_exit = (mode == MODE_MOUSE) && !(&joy_a_n) && !mouse_strobe;
        take_edge  = (mode == MODE_MOUSE) && !mouse_exit && stra_edge;
        snap_take  = take_edge && (nib == NIB_N0);
        tmo_fire   = (mode == MODE_MOUSE) && !take_edge && ({1'b0, tmo_cnt} == TMO_FIRE);

        // A strobe landing on the snapshot starts the fresh accumulation from zero.
        acc_x_base = snap_take ? '0 : acc_x;
        acc_y_base = snap_take ? '0 : acc_y;

        // In N0 the snapshot is being taken this cycle, so read the accumulator directly.
        snap_x_view = (nib == NIB_N0) ? acc_x : snap_x;
        nib_out     = snap_x_view[7:4];
        case (nib)
            NIB_N0:  nib_out = snap_x_view[7:4];
            NIB_N1:  nib_out = snap_x_view[3:0];
            NIB_N2:  nib_out = snap_y[7:4];
            NIB_N3:  nib_out = snap_y[3:0];
            default: nib_out = snap_x_view[7:4];
        endcase
    end

    // Next-state logic for the mode and nibble FSMs.
    always_comb begin
        mode_next = mode;
        nib_next  = nib;

        unique case (mode)
            MODE_JOY:   if (mouse_strobe) mode_next = MODE_MOUSE;
            MODE_MOUSE: if (mouse_exit)   mode_next = MODE_JOY;
            default:    mode_next = MODE_JOY;
        endcase

        if (mode != MODE_MOUSE || mouse_exit) begin
            nib_next = NIB_N0;
        end else if (take_edge) begin
            unique case (nib)
                NIB_N0:  nib_next = NIB_N1;
                NIB_N1:  nib_next = NIB_N2;
                NIB_N2:  nib_next = NIB_N3;
                NIB_N3:  nib_next = NIB_N0;
                default: nib_next = NIB_N0;
            endcase
        end else if (tmo_fire) begin
            nib_next = NIB_N0;
        end
    end

    // State registers for the mode and nibble FSMs.
    // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mode <= MODE_JOY;
            nib  <= NIB_N0;
        end else begin
            mode <= mode_next;
            nib  <= nib_next;
        end
    end

    // Datapath: strobe sync, accumulators, snapshots, timeout and pin drivers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            stra_q  <= 1'b0;
            acc_x   <= '0;
            acc_y   <= '0;
            snap_x  <= '0;
            snap_y  <= '0;
            btn_q   <= 2'b00;
            tmo_cnt <= '0;
            port_a  <= 6'h3F;
        end else begin
            stra_q <= stra;

            if (mouse_strobe) begin
                acc_x <= acc_x_sum;
                acc_y <= acc_y_sum;
                btn_q <= mouse_btn;
            end else if (snap_take) begin
                acc_x <= '0;
                acc_y <= '0;
            end

            if (snap_take) begin
                snap_x <= acc_x;
                snap_y <= acc_y;
            end

            if (mode != MODE_MOUSE || mouse_exit) begin
                tmo_cnt <= '0;
            end else if (take_edge) begin
                tmo_cnt <= TMO_LOAD;
            end else if (tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - TMO_ONE;
            end

            if (mode == MODE_MOUSE) begin
                port_a[5:4] <= ~btn_q;
                if (take_edge) begin
                    port_a[3:0] <= nib_out;
                end
            end else begin
                // Strobe is sampled on the same edge as stra_q, so the pins track joy_a_n | stra_q.
                port_a <= joy_a_n | {6{stra}};
            end
        end
    end

    assign mouse_active = (mode == MODE_MOUSE);

endmodule

// File: tb/tb_msx_joyport_ctrl.sv
// Self-checking bench for msx_joyport_ctrl: directed scenarios plus random
// mouse traffic checked against a transaction-level model.
module tb_msx_joyport_ctrl;

    localparam int T = 32;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [5:0]  joy_a_n;
    logic [8:0]  mouse_x;
    logic [8:0]  mouse_y;
    logic [1:0]  mouse_btn;
    logic        mouse_strobe;
    logic        stra;
    logic [5:0]  port_a;
    logic        mouse_active;

    int errors = 0;
    int checks = 0;

    // Model: clamped motion totals, snapshot, read position, latched buttons.
    int         mx, my;
    logic [7:0] sx, sy;
    int         idx;
    logic [1:0] mbtn;
    logic [3:0] last_nib;

    msx_joyport_ctrl #(.TIMEOUT(T)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .joy_a_n      (joy_a_n),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .mouse_btn    (mouse_btn),
        .mouse_strobe (mouse_strobe),
        .stra         (stra),
        .port_a       (port_a),
        .mouse_active (mouse_active)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int clamp(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic model_reset();
        mx = 0; my = 0; sx = '0; sy = '0; idx = 0; mbtn = 2'b00; last_nib = '0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        joy_a_n      = 6'h3F;
        mouse_strobe = 1'b0;
        step();
        step();
        reset = 1'b0;
        model_reset();
        step();
    endtask

    task automatic strobe(input logic signed [8:0] x, input logic signed [8:0] y, input logic [1:0] btn);
        mouse_x = x; mouse_y = y; mouse_btn = btn; mouse_strobe = 1'b1;
        step();
        mouse_strobe = 1'b0;
        mx   = clamp(mx - int'(x));
        my   = clamp(my + int'(y));
        mbtn = btn;
    endtask

    // One strobe toggle, optionally with a coincident mouse strobe; checks the driven pins.
    task automatic toggle(input string name, input logic with_strobe,
                          input logic signed [8:0] x, input logic signed [8:0] y, input logic [1:0] btn);
        logic [3:0] exp_nib;
        logic [5:0] expv;
        stra = ~stra;
        if (with_strobe) begin
            mouse_x = x; mouse_y = y; mouse_btn = btn; mouse_strobe = 1'b1;
        end
        step();
        mouse_strobe = 1'b0;
        case (idx)
            0: begin
                sx = 8'(mx); sy = 8'(my); mx = 0; my = 0;
                exp_nib = sx[7:4];
            end
            1:       exp_nib = sx[3:0];
            2:       exp_nib = sy[7:4];
            default: exp_nib = sy[3:0];
        endcase
        expv = {~mbtn, exp_nib};
        if (with_strobe) begin
            mx   = clamp(mx - int'(x));
            my   = clamp(my + int'(y));
            mbtn = btn;
        end
        idx      = (idx + 1) % 4;
        last_nib = exp_nib;
        checks++;
        if (port_a !== expv) begin
            errors++;
            $display("FAIL %s: port_a=%b expected %b", name, port_a, expv);
        end
    endtask

    task automatic toggle_plain(input string name);
        toggle(name, 1'b0, 9'sd0, 9'sd0, 2'b00);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
        if (n >= T) idx = 0;
    endtask

    task automatic check_mode(input string name, input logic expv);
        checks++;
        if (mouse_active !== expv) begin
            errors++;
            $display("FAIL %s: mouse_active=%b expected %b", name, mouse_active, expv);
        end
    endtask

    task automatic check_port(input string name, input logic [5:0] expv);
        checks++;
        if (port_a !== expv) begin
            errors++;
            $display("FAIL %s: port_a=%b expected %b", name, port_a, expv);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        check_port("reset_port_a", 6'h3F);
        check_mode("reset_mode", 1'b0);
        do_reset();
    endtask

    task automatic test_joystick();
        joy_a_n = 6'b111110; stra = 1'b0;
        step();
        step();
        check_port("joy_stra0", 6'b111110);
        stra = 1'b1;
        step();
        check_port("joy_stra1", 6'h3F);
        for (int i = 0; i < 10; i++) begin
            joy_a_n = 6'($urandom_range(0, 63));
            stra    = 1'($urandom_range(0, 1));
            step();
            check_port("joy_random", joy_a_n | {6{stra}});
            check_mode("joy_mode", 1'b0);
        end
        joy_a_n = 6'h3F;
        step();
    endtask

    task automatic test_mouse_read();
        do_reset();
        strobe(9'sd3, 9'sd5, 2'b01);
        step();
        check_mode("mouse_enter", 1'b1);
        toggle_plain("read_xh");
        check_port("read_xh_lit", 6'b10_1111);
        toggle_plain("read_xl");
        check_port("read_xl_lit", 6'b10_1101);
        toggle_plain("read_yh");
        check_port("read_yh_lit", 6'b10_0000);
        toggle_plain("read_yl");
        check_port("read_yl_lit", 6'b10_0101);
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (5) strobe(-9'sd100, 9'sd0, 2'b00);
        step();
        toggle_plain("sat_pos_xh");
        check_port("sat_pos_xh_lit", 6'b11_0111);
        toggle_plain("sat_pos_xl");
        check_port("sat_pos_xl_lit", 6'b11_1111);
        toggle_plain("sat_pos_yh");
        toggle_plain("sat_pos_yl");
        repeat (3) strobe(9'sd200, -9'sd200, 2'b10);
        toggle_plain("sat_neg_xh");
        toggle_plain("sat_neg_xl");
        toggle_plain("sat_neg_yh");
        toggle_plain("sat_neg_yl");
    endtask

    task automatic test_timeout();
        do_reset();
        strobe(9'sd7, -9'sd9, 2'b11);
        step();
        toggle_plain("tmo_xh");
        toggle_plain("tmo_xl");
        idle(T + 4);
        check_port("tmo_hold", {~mbtn, last_nib});
        strobe(-9'sd20, 9'sd33, 2'b01);
        toggle_plain("tmo_restart_xh");
        toggle_plain("tmo_restart_xl");
        idle(T / 2);
        toggle_plain("tmo_short_yh");
        toggle_plain("tmo_short_yl");
    endtask

    task automatic test_coincidence();
        do_reset();
        strobe(9'sd4, 9'sd6, 2'b01);
        step();
        toggle("coin_xh", 1'b1, 9'sd0, 9'sd2, 2'b01);
        toggle_plain("coin_xl");
        toggle_plain("coin_yh_old");
        toggle_plain("coin_yl_old");
        check_port("coin_yl_old_lit", 6'b10_0110);
        toggle_plain("coin2_xh");
        toggle_plain("coin2_xl");
        toggle_plain("coin2_yh");
        toggle_plain("coin2_yl_new");
        check_port("coin2_yl_new_lit", 6'b10_0010);
    endtask

    task automatic test_mode_exit();
        do_reset();
        strobe(9'sd1, 9'sd1, 2'b00);
        step();
        toggle_plain("exit_xh");
        strobe(9'sd2, 9'sd3, 2'b00);
        joy_a_n = 6'b101111;
        step();
        check_mode("exit_mode", 1'b0);
        step();
        check_port("exit_joy_pins", 6'b101111 | {6{stra}});
        idx = 0;
        joy_a_n = 6'h3F;
        step();
        strobe(9'sd0, 9'sd0, 2'b00);
        step();
        toggle_plain("exit_kept_xh");
        toggle_plain("exit_kept_xl");
        toggle_plain("exit_kept_yh");
        toggle_plain("exit_kept_yl");

        // Reset in the middle of a read abandons it.
        strobe(9'sd9, 9'sd9, 2'b11);
        toggle_plain("rst_mid_xh");
        toggle_plain("rst_mid_xl");
        reset = 1'b1;
        step();
        check_port("rst_mid_port", 6'h3F);
        check_mode("rst_mid_mode", 1'b0);
        reset = 1'b0;
        model_reset();
        step();
        step();
        strobe(9'sd5, 9'sd5, 2'b00);
        step();
        toggle_plain("rst_first_xh");
        toggle_plain("rst_first_xl");
    endtask

    task automatic test_random();
        int n_str;
        do_reset();
        strobe(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 2'($urandom_range(0, 3)));
        step();
        for (int i = 0; i < 48; i++) begin
            n_str = $urandom_range(0, 2);
            for (int k = 0; k < n_str; k++) begin
                strobe(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 2'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 3) == 0) begin
                toggle("rand_coin", 1'b1, 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
                       2'($urandom_range(0, 3)));
            end else begin
                toggle_plain("rand_read");
            end
            check_mode("rand_mode", 1'b1);
        end
    endtask

    initial begin
        reset        = 1'b1;
        joy_a_n      = 6'h3F;
        mouse_x      = '0;
        mouse_y      = '0;
        mouse_btn    = 2'b00;
        mouse_strobe = 1'b0;
        stra         = 1'b0;
        model_reset();

        test_reset();
        test_joystick();
        test_mouse_read();
        test_saturation();
        test_timeout();
        test_coincidence();
        test_mode_exit();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
